uart_stat_reporter: RTL and testbench
=====================================

Name: uart_stat_reporter

Overview:
- Parametrised UART block that reports a vector of pet statistics as formatted ASCII lines, and receives command bytes.
- Replaces the fixed 6-stat, button-only, hard-coded 115200-baud status dump.
- Adds configurable channel count, stat width and baud divisor, per-channel two-character tags, and 3-digit decimal formatting of any value up to 511.
- Adds a serial command trigger, RX framing-error detection, and a one-deep pending-request latch.
- Sits between the game core (stats, command consumer) and the board UART pins.

Parameters:
- CLK_DIV, 234, clock cycles per UART bit (27 MHz / 115200); legal range 4..65535.
- NUM_STATS, 6, number of reported stat channels; legal range 1..16.
- STAT_W, 5, width of each stat value; legal range 1..9.
- CMD_BYTE, 8'h73, received byte ('s') that triggers a report.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- uart_tx  out  1  serial output; idle high.
- trigger  in  1  report request; level input, rising edge detected internally.
- stats  in  NUM_STATS*STAT_W  packed stat values; channel i is at [i*STAT_W +: STAT_W].
- tags  in  NUM_STATS*16  two ASCII characters per channel; [i*16+15 -: 8] is sent first.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- frame_err  out  1  one-cycle pulse when a received stop bit samples 0.
- busy  out  1  high while a report is being transmitted.

Behaviour:
- Reset:
  - uart_tx=1; rx_valid=0; frame_err=0; busy=0; rx_data=0.
  - The pending latch and all counters are cleared.
  - Reset mid-frame aborts immediately; uart_tx is 1 on the cycle after rst is sampled high.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser before any use.
- RX state machine, states IDLE, START, DATA, STOP:
  - IDLE->START on a synchronised 0.
  - START samples at CLK_DIV/2 cycles. If the line is high there, return to IDLE (glitch rejected). Otherwise go to DATA.
  - DATA samples 8 bits LSB-first, one every CLK_DIV cycles.
  - STOP samples one CLK_DIV later:
    - 1: rx_data<=byte, rx_valid pulses.
    - 0: frame_err pulses, rx_data is unchanged, no rx_valid.
  - Return to IDLE after the STOP sample.
- Report request: a rising edge of trigger, or rx_valid with rx_data==CMD_BYTE. A byte that equals CMD_BYTE is still presented on rx_data/rx_valid.
- Request handling:
  - Request while idle: busy rises next cycle and the start bit begins that cycle.
  - Request while busy: sets a pending flag. Multiple requests while busy collapse to one.
  - Pending flag set at report end: the next report starts the cycle after the final stop bit ends, with no gap.
  - Simultaneous trigger edge and CMD_BYTE: counts as one request.
- Snapshot: stats and tags are registered on the cycle the report starts. Later changes do not affect the report in flight.
- Report format per channel i, in order 0..NUM_STATS-1, 9 bytes each:
  - tag[hi], tag[lo], ':', ' ', hundreds, tens, units, '\r', '\n'.
  - Digits are ASCII '0'+d and always 3 digits with leading zeros. Value 5 is sent as "005"; 511 as "511".
  - Total report length is 9*NUM_STATS bytes.
- Decimal conversion: iterative (subtract 100/10 or double-dabble). It must complete while the tag bytes are being sent. No inter-byte idle time is permitted.
- TX frame timing:
  - Start bit 0, 8 data bits LSB-first, stop bit 1; each bit lasts exactly CLK_DIV cycles.
  - Bytes are sent back-to-back, 10*CLK_DIV cycles per byte.
- busy falls on the cycle after the last stop bit completes, unless a pending report starts. In that case busy stays high continuously.
- RX and TX operate fully independently, so full-duplex is supported.

Decomposition:
- Package uart_pkg:
  - ASCII constants for ':', ' ', '0', CR and LF.
  - BYTES_PER_LINE=9.
  - RX state enum and report-sequencer state enum.
- Sub-module uart_tx_byte:
  - Single-byte serialiser with a valid/ready handshake.
  - Takes byte and valid; ready is high when idle.
  - Holds CLK_DIV as a parameter.
- The top level contains the RX FSM, request logic, snapshot, decimal converter and byte sequencer.

Test Plan (bench uses CLK_DIV=8, NUM_STATS=2, STAT_W=9):
- Idle report: stats={ch1=9'd511, ch0=9'd5}, tags={"HA","HU"}, pulse trigger. Expected: uart_tx decodes "HU: 005\r\nHA: 511\r\n" (18 bytes). busy is high for exactly 18*80 cycles.
- Serial command: send 0x73 on uart_rx. Expected: rx_valid pulse with rx_data=0x73, and a report starts within 2 cycles. Send 0x41: rx_valid pulses, no report.
- Framing error: send 0x55 with stop bit 0. Expected: frame_err pulses once, no rx_valid, rx_data keeps its previous value.
- Pending collapse: 3 trigger edges during a report. Expected: exactly one extra report, back-to-back, busy never drops between the two, total 36 bytes.
- Snapshot: change ch0 from 5 to 100 during the first byte. Expected: the report shows "005". The next report shows "100".
- Reset mid-byte: assert rst during bit 3 of byte 2. Expected: uart_tx=1 and busy=0 the next cycle. No rx_valid, and a fresh trigger produces a complete report.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART stat reporter.
// The byte layout of a report line is defined here.
package uart_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int BYTES_PER_LINE = 9;
  localparam int VAL_W          = 9;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_SEND, SEQ_LAST} seq_state_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser (start, 8 data bits LSB-first, stop).
// Handshake: a byte is accepted on a cycle where i_valid and o_ready are both high.
module uart_tx_byte #(
  parameter int CLK_DIV = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  logic        r_active;
  logic        r_tx;
  logic [8:0]  r_shift;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_div_cnt;
  logic        w_last;

  // Ready also in the final stop-bit cycle so consecutive frames abut with no gap.
  assign w_last  = r_active && (r_bit_cnt == 4'd9) && (r_div_cnt == DIV_MAX);
  assign o_ready = !r_active || w_last;
  assign o_tx    = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (i_valid && o_ready) begin
      r_active  <= 1'b1;
      r_tx      <= 1'b0;
      r_shift   <= {1'b1, i_data};
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (r_active) begin
      if (r_div_cnt == DIV_MAX) begin
        r_div_cnt <= '0;
        if (r_bit_cnt == 4'd9) begin
          r_active <= 1'b0;
        end else begin
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_stat_reporter.sv
// Receives command bytes and transmits a stat report as "TG: ddd\r\n" per channel.
// RX and TX paths are independent; the report sequencer keeps the serialiser fed back-to-back.
module uart_stat_reporter
  import uart_pkg::*;
#(
  parameter int          CLK_DIV   = 234,
  parameter int          NUM_STATS = 6,
  parameter int          STAT_W    = 5,
  parameter logic [7:0]  CMD_BYTE  = 8'h73
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic                          trigger,
  input  logic [NUM_STATS*STAT_W-1:0]   stats,
  input  logic [NUM_STATS*16-1:0]       tags,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int              CH_W     = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
  localparam logic [15:0]     DIV_MAX  = 16'(CLK_DIV - 1);
  localparam logic [15:0]     HALF_MAX = 16'(CLK_DIV / 2 - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_STATS - 1);
  localparam logic [3:0]      LAST_POS = 4'(BYTES_PER_LINE - 1);

  logic        r_rx_s1, r_rx_s2;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1     <= uart_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_MAX) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == DIV_MAX) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == DIV_MAX) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

  logic             r_trig_d;
  seq_state_t       r_seq_state;
  logic             r_busy;
  logic             r_pending;
  logic [CH_W-1:0]  r_ch;
  logic [3:0]       r_pos;
  logic [15:0]      r_tag_arr  [NUM_STATS];
  logic [VAL_W-1:0] r_stat_arr [NUM_STATS];
  logic [VAL_W-1:0] r_cv_rem;
  logic [3:0]       r_cv_h, r_cv_t;

  logic             w_req, w_end, w_start, w_send;
  logic             w_tx_valid, w_tx_ready, w_fire, w_cv_load;
  logic [7:0]       w_tx_data;
  logic [VAL_W-1:0] w_cv_in;

  assign w_req      = (trigger && !r_trig_d) || (r_rx_valid && (r_rx_data == CMD_BYTE));
  assign w_end      = (r_seq_state == SEQ_LAST) && w_tx_ready;
  assign w_start    = ((r_seq_state == SEQ_IDLE) && w_req) || (w_end && (r_pending || w_req));
  assign w_send     = (r_seq_state == SEQ_SEND);
  assign w_tx_valid = w_start || w_send;
  assign w_fire     = w_tx_valid && w_tx_ready;
  assign w_cv_load  = w_fire && (!w_send || (r_pos == 4'd0));
  assign w_cv_in    = w_send ? r_stat_arr[r_ch] : VAL_W'(stats[STAT_W-1:0]);

  // The first byte of a report goes out on the start cycle, before the snapshot is visible.
  always_comb begin
    w_tx_data = tags[15:8];
    if (w_send) begin
      case (r_pos)
        4'd0:    w_tx_data = r_tag_arr[r_ch][15:8];
        4'd1:    w_tx_data = r_tag_arr[r_ch][7:0];
        4'd2:    w_tx_data = ASCII_COLON;
        4'd3:    w_tx_data = ASCII_SPACE;
        4'd4:    w_tx_data = ascii_digit(r_cv_h);
        4'd5:    w_tx_data = ascii_digit(r_cv_t);
        4'd6:    w_tx_data = ascii_digit(r_cv_rem[3:0]);
        4'd7:    w_tx_data = ASCII_CR;
        default: w_tx_data = ASCII_LF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_d    <= 1'b0;
      r_seq_state <= SEQ_IDLE;
      r_busy      <= 1'b0;
      r_pending   <= 1'b0;
      r_ch        <= '0;
      r_pos       <= '0;
    end else begin
      r_trig_d <= trigger;
      if (w_start) begin
        r_seq_state <= SEQ_SEND;
        r_busy      <= 1'b1;
        r_pending   <= 1'b0;
        r_ch        <= '0;
        r_pos       <= 4'd1;
      end else begin
        if (w_req && r_busy) r_pending <= 1'b1;
        if (w_send && w_fire) begin
          if (r_pos == LAST_POS) begin
            r_pos <= '0;
            if (r_ch == LAST_CH) r_seq_state <= SEQ_LAST;
            else                 r_ch <= r_ch + 1'b1;
          end else begin
            r_pos <= r_pos + 1'b1;
          end
        end
        if (w_end) begin
          r_seq_state <= SEQ_IDLE;
          r_busy      <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      for (int i = 0; i < NUM_STATS; i++) begin
        r_tag_arr[i]  <= tags[i*16 +: 16];
        r_stat_arr[i] <= VAL_W'(stats[i*STAT_W +: STAT_W]);
      end
    end
  end

  // Repeated subtraction finishes well inside the two tag bytes of each line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cv_rem <= '0;
      r_cv_h   <= '0;
      r_cv_t   <= '0;
    end else if (w_cv_load) begin
      r_cv_rem <= w_cv_in;
      r_cv_h   <= '0;
      r_cv_t   <= '0;
    end else if (r_cv_rem >= 9'd100) begin
      r_cv_rem <= r_cv_rem - 9'd100;
      r_cv_h   <= r_cv_h + 1'b1;
    end else if (r_cv_rem >= 9'd10) begin
      r_cv_rem <= r_cv_rem - 9'd10;
      r_cv_t   <= r_cv_t + 1'b1;
    end
  end

  assign busy = r_busy;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_tx_valid),
    .i_data  (w_tx_data),
    .o_ready (w_tx_ready),
    .o_tx    (uart_tx)
  );

endmodule

// File: tb/tb_uart_stat_reporter.sv
// Directed bench for uart_stat_reporter: decodes uart_tx into bytes and checks
// report content, busy timing, RX command/framing behaviour and reset abort.
module tb_uart_stat_reporter;

  localparam int CLK_DIV   = 8;
  localparam int NUM_STATS = 2;
  localparam int STAT_W    = 9;
  localparam int BYTE_CYC  = 10 * CLK_DIV;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        uart_rx = 1'b1;
  logic                        trigger = 1'b0;
  logic [NUM_STATS*STAT_W-1:0] stats;
  logic [NUM_STATS*16-1:0]     tags;
  logic                        uart_tx;
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        frame_err;
  logic                        busy;

  always #5 clk = ~clk;

  uart_stat_reporter #(
    .CLK_DIV(CLK_DIV), .NUM_STATS(NUM_STATS), .STAT_W(STAT_W), .CMD_BYTE(8'h73)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx), .trigger(trigger),
    .stats(stats), .tags(tags), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Line monitor: decodes uart_tx and tracks rx/busy events on the falling edge.
  bit         mon_act = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  int         rxv_cnt = 0, rxv_cyc = 0, fe_cnt = 0;
  logic [7:0] rxv_last = 8'h00;
  int         rise_cnt = 0, rise_cyc = 0, fall_cnt = 0, fall_cyc = 0;
  logic       tx_at_rise = 1'b1;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_act   = 0;
      busy_prev = 1'b0;
    end else begin
      if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          mon_act = 1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CLK_DIV == CLK_DIV / 2) begin
          if (mon_cnt / CLK_DIV >= 1 && mon_cnt / CLK_DIV <= 8) begin
            mon_byte[mon_cnt / CLK_DIV - 1] = uart_tx;
          end else if (mon_cnt / CLK_DIV == 9) begin
            got_q.push_back(mon_byte);
            mon_act = 0;
          end
        end
      end
      if (rx_valid === 1'b1) begin
        rxv_cnt++;
        rxv_last = rx_data;
        rxv_cyc  = cyc;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (busy && !busy_prev) begin
        rise_cnt++;
        rise_cyc   = cyc;
        tx_at_rise = uart_tx;
      end
      if (!busy && busy_prev) begin
        fall_cnt++;
        fall_cyc = cyc;
      end
      busy_prev = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic load_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic test_reset;
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
  endtask

  task automatic test_idle_report;
    bit to;
    int r0;
    got_q.delete(); exp_q.delete();
    load_exp("HU: 005\r\nHA: 511\r\n");
    r0 = rise_cnt;
    pulse_trigger();
    wait_idle(to);
    tick(2);
    n_cmp++; if (to) begin n_fail++; $display("FAIL idle_timeout: busy still high"); end
    n_cmp++; if (rise_cnt !== r0 + 1) begin n_fail++; $display("FAIL idle_rise: got %0d rises want 1", rise_cnt - r0); end
    n_cmp++; if (tx_at_rise !== 1'b0) begin n_fail++; $display("FAIL idle_start_bit: tx=%b at busy rise want 0", tx_at_rise); end
    n_cmp++; if (fall_cyc - rise_cyc !== 18 * BYTE_CYC) begin n_fail++; $display("FAIL idle_busy_len: got %0d want %0d", fall_cyc - rise_cyc, 18 * BYTE_CYC); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL idle_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL idle_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_serial_cmd;
    bit to;
    int v0, r0, d;
    got_q.delete(); exp_q.delete();
    load_exp("HU: 005\r\nHA: 511\r\n");
    v0 = rxv_cnt; r0 = rise_cnt;
    send_rx(8'h73, 1'b1);
    wait_idle(to);
    tick(2);
    d = rise_cyc - rxv_cyc;
    n_cmp++; if (to) begin n_fail++; $display("FAIL cmd_timeout: busy still high"); end
    n_cmp++; if (rxv_cnt !== v0 + 1) begin n_fail++; $display("FAIL cmd_rx_valid: got %0d pulses want 1", rxv_cnt - v0); end
    n_cmp++; if (rxv_last !== 8'h73) begin n_fail++; $display("FAIL cmd_rx_data: got %h want 73", rxv_last); end
    n_cmp++; if (rise_cnt !== r0 + 1) begin n_fail++; $display("FAIL cmd_report: got %0d reports want 1", rise_cnt - r0); end
    n_cmp++; if (!(d >= 1 && d <= 2)) begin n_fail++; $display("FAIL cmd_latency: got %0d cycles want 1..2", d); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL cmd_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cmd_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    r0 = rise_cnt;
    send_rx(8'h41, 1'b1);
    tick(20);
    n_cmp++; if (rxv_cnt !== v0 + 2) begin n_fail++; $display("FAIL other_rx_valid: got %0d pulses want 2", rxv_cnt - v0); end
    n_cmp++; if (rx_data !== 8'h41) begin n_fail++; $display("FAIL other_rx_data: got %h want 41", rx_data); end
    n_cmp++; if (rise_cnt !== r0 || busy !== 1'b0) begin n_fail++; $display("FAIL other_no_report: rises %0d busy %b want 0 0", rise_cnt - r0, busy); end
  endtask

  task automatic test_frame_err;
    int f0, v0;
    f0 = fe_cnt; v0 = rxv_cnt;
    send_rx(8'h55, 1'b0);
    tick(30);
    n_cmp++; if (fe_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_cnt - f0); end
    n_cmp++; if (rxv_cnt !== v0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d pulses want 0", rxv_cnt - v0); end
    n_cmp++; if (rx_data !== 8'h41) begin n_fail++; $display("FAIL ferr_rx_data: got %h want 41", rx_data); end
  endtask

  task automatic test_back_to_back;
    bit to;
    int r0, f0;
    got_q.delete(); exp_q.delete();
    load_exp("HU: 005\r\nHA: 511\r\n");
    load_exp("HU: 005\r\nHA: 511\r\n");
    r0 = rise_cnt; f0 = fall_cnt;
    pulse_trigger();
    tick(100);
    for (int k = 0; k < 3; k++) begin
      pulse_trigger();
      tick(150);
    end
    wait_idle(to);
    tick(2);
    n_cmp++; if (to) begin n_fail++; $display("FAIL b2b_timeout: busy still high"); end
    n_cmp++; if (rise_cnt !== r0 + 1) begin n_fail++; $display("FAIL b2b_rises: got %0d want 1", rise_cnt - r0); end
    n_cmp++; if (fall_cnt !== f0 + 1) begin n_fail++; $display("FAIL b2b_falls: got %0d want 1", fall_cnt - f0); end
    n_cmp++; if (fall_cyc - rise_cyc !== 36 * BYTE_CYC) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want %0d", fall_cyc - rise_cyc, 36 * BYTE_CYC); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_snapshot;
    bit to;
    got_q.delete(); exp_q.delete();
    load_exp("HU: 005\r\nHA: 511\r\n");
    stats = {9'd511, 9'd5};
    pulse_trigger();
    tick(20);
    stats = {9'd511, 9'd100};
    wait_idle(to);
    tick(2);
    n_cmp++; if (to) begin n_fail++; $display("FAIL snap_timeout: busy still high"); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL snap_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL snap_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    load_exp("HU: 100\r\nHA: 511\r\n");
    pulse_trigger();
    wait_idle(to);
    tick(2);
    n_cmp++; if (to) begin n_fail++; $display("FAIL snap2_timeout: busy still high"); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL snap2_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL snap2_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    stats = {9'd511, 9'd5};
  endtask

  task automatic test_reset_mid;
    bit to;
    int v0;
    v0 = rxv_cnt;
    pulse_trigger();
    // Second byte is 'U' (0x55); its data bit 3 is a 0 on the line.
    tick(BYTE_CYC + 4 * CLK_DIV + 3);
    n_cmp++; if (busy !== 1'b1 || uart_tx !== 1'b0) begin n_fail++; $display("FAIL rmid_pre: busy %b tx %b want 1 0", busy, uart_tx); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", uart_tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick(5);
    n_cmp++; if (rxv_cnt !== v0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d pulses want 0", rxv_cnt - v0); end
    got_q.delete(); exp_q.delete();
    load_exp("HU: 005\r\nHA: 511\r\n");
    pulse_trigger();
    wait_idle(to);
    tick(2);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rmid_timeout: busy still high"); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmid_len: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    stats = {9'd511, 9'd5};
    tags  = {"HA", "HU"};
    tick(5);
    rst = 1'b0;
    tick(2);
    test_reset();
    test_idle_report();
    tick(10);
    test_serial_cmd();
    tick(10);
    test_frame_err();
    tick(10);
    test_back_to_back();
    tick(10);
    test_snapshot();
    tick(10);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
